pc_seq_unit: RTL and testbench
==============================

Name: pc_seq_unit

Overview:
Parametrised successor to the plain PC register for the BIP-I core.
- Holds the program counter and computes the next value itself: sequential increment, absolute jump, signed relative branch, call/return through an internal return-address stack (RAS), and halt/resume.
- Sits between the instruction decoder (supplies op, target, offset) and program memory (consumes o_PCval).

Parameters:
- PCLEN, 11, program counter width in bits.
- RAS_DEPTH, 4, return-address stack entries (power of two, 2..16).
- RESET_VEC, 0, PC value loaded on reset.
- TRAP_VEC, 2**PCLEN-1, PC value loaded on a stack fault; used only with PC_TRAP_EN.

Ports:
- i_clk, input, 1, clock; all registers update on the falling edge.
- i_rst, input, 1, synchronous active-high reset; highest priority.
- i_en, input, 1, advance enable; low means hold all state.
- i_op, input, 3, operation: 0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5 HALT, 6-7 reserved.
- i_target, input, PCLEN, absolute target for JUMP and CALL.
- i_offset, input, PCLEN, two's-complement offset for BRANCH.
- i_resume, input, 1, leave HALT state.
- o_PCval, output, PCLEN, current PC.
- o_halted, output, 1, high while in HALT state.
- o_ras_depth, output, $clog2(RAS_DEPTH)+1, number of valid RAS entries.
- o_ras_full, output, 1, depth == RAS_DEPTH.
- o_ras_empty, output, 1, depth == 0.
- o_trap, output, 1, one-cycle stack-fault pulse; present only with PC_TRAP_EN.

Behaviour:
- Reset (i_rst high at a falling edge): PC = RESET_VEC, state RUN, RAS depth 0, o_halted 0, o_trap 0. RAS contents are don't-care.
- Latency: all outputs are registered; a new PC is visible one falling edge after the op is sampled.
- States: RUN and HALT.
- RUN with i_en low: everything holds and i_op is ignored.
- RUN with i_en high:
  - NEXT: PC = PC+1, modulo 2**PCLEN (wraps from all-ones to 0).
  - JUMP: PC = i_target.
  - BRANCH: PC = PC + i_offset, modulo 2**PCLEN (sign implicit in the wrap).
  - CALL: push PC+1 (wrapped), PC = i_target.
  - RET: pop the top entry, PC = popped value.
  - HALT: PC holds, state goes to HALT, o_halted = 1 on the same edge.
  - Reserved ops (6-7): behave as a hold, with no state change.
- HALT state: PC and RAS hold; i_en and i_op are ignored.
  - i_resume high: state = RUN and o_halted = 0 on the next edge; PC unchanged.
  - i_resume in RUN has no effect.
- RAS is a LIFO of PCLEN-wide entries.
  - CALL increments depth; RET decrements it.
  - Simultaneous push and pop cannot occur (single op per cycle).
- Stack faults without PC_TRAP_EN:
  - CALL when full: push discarded, depth stays RAS_DEPTH, jump still taken.
  - RET when empty: PC = PC+1, depth stays 0.
- Reset during HALT or with a full RAS restores reset values on that edge.

Optional Feature:
- Macro: PC_TRAP_EN.
- Defined: CALL-when-full or RET-when-empty loads PC = TRAP_VEC and pulses o_trap high for exactly one cycle. RAS is unchanged and the state stays RUN. o_trap is 0 at all other times, including reset.
- Undefined: o_trap port absent, TRAP_VEC unused, fault behaviour as listed under Behaviour.

Decomposition:
- Shared package pc_pkg holds:
  - op encodings OP_NEXT..OP_HALT, 3 bits;
  - state encodings ST_RUN and ST_HALT.
- One sub-module, pc_ras: parametrised LIFO with push/pop, data in/out, depth, full and empty.
  - Clocked on the same falling edge with the same synchronous reset.
  - Instantiated once inside pc_seq_unit.

Test Plan:
- Reset, then 3x NEXT with i_en=1 -> PC 0,1,2,3. With i_en=0 for 2 cycles, PC stays 3.
- PC=0x7FF, NEXT -> PC=0x000. PC=0x005, BRANCH with offset 0x7FE (-2) -> PC=0x003.
- CALL 0x100 from PC 0x010, then CALL 0x200 from 0x100, then 2x RET -> PC 0x100, 0x200, 0x101, 0x011; depth goes 1,2,1,0.
- 5x CALL with RAS_DEPTH=4 -> o_ras_full=1 and depth=4 after the 4th. The 5th CALL still jumps; with PC_TRAP_EN it instead gives PC=0x7FF and o_trap high for one cycle.
- RET with empty RAS from PC 0x020 -> PC=0x021, or with PC_TRAP_EN PC=0x7FF plus a one-cycle o_trap.
- HALT at PC 0x040 -> o_halted=1. NEXT with i_en=1 for 3 cycles leaves PC at 0x040. i_resume=1 -> o_halted=0, and the next NEXT gives PC=0x041. i_rst asserted while halted -> PC=0, o_halted=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared definitions for the BIP-I program-counter sequencer.
// Holds the operation and state encodings, plus a width helper for the return-address stack.
package pc_pkg;

   // Operation codes supplied by the instruction decoder; 6 and 7 are reserved.
   typedef enum logic [2:0] {
      OP_NEXT   = 3'd0,
      OP_JUMP   = 3'd1,
      OP_BRANCH = 3'd2,
      OP_CALL   = 3'd3,
      OP_RET    = 3'd4,
      OP_HALT   = 3'd5
   } pc_op_e;

   // Sequencer control states.
   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } pc_state_e;

   localparam int OP_W = 3;

   // Width of a counter that must hold 0..depth inclusive.
   function automatic int ras_depth_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/pc_seq_unit_if.sv
// Decoder-side bus of the program-counter sequencer.
// Optional: PC_TRAP_EN adds the o_trap stack-fault pulse.
interface pc_seq_unit_if
   import pc_pkg::*;
#(
   parameter int PCLEN     = 11,
   parameter int RAS_DEPTH = 4
);
   localparam int DW = ras_depth_w(RAS_DEPTH);

   logic              i_en;
   logic [OP_W-1:0]   i_op;
   logic [PCLEN-1:0]  i_target;
   logic [PCLEN-1:0]  i_offset;
   logic              i_resume;
   logic [PCLEN-1:0]  o_PCval;
   logic              o_halted;
   logic [DW-1:0]     o_ras_depth;
   logic              o_ras_full;
   logic              o_ras_empty;
`ifdef PC_TRAP_EN
   logic              o_trap;
`endif

   // Decoder / program-memory side.
   modport master (
      output i_en, i_op, i_target, i_offset, i_resume,
`ifdef PC_TRAP_EN
      input  o_trap,
`endif
      input  o_PCval, o_halted, o_ras_depth, o_ras_full, o_ras_empty
   );

   // Sequencer side.
   modport slave (
      input  i_en, i_op, i_target, i_offset, i_resume,
`ifdef PC_TRAP_EN
      output o_trap,
`endif
      output o_PCval, o_halted, o_ras_depth, o_ras_full, o_ras_empty
   );

endinterface

// File: rtl/pc_ras.sv
// Return-address stack: a small LIFO with depth count, full and empty flags.
// Entries are not reset; only the depth counter is. Push when full and pop when empty are ignored.
module pc_ras
   import pc_pkg::*;
#(
   parameter int  WIDTH = 11,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int DW    = ras_depth_w(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic [DW-1:0]    o_depth,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [DW-1:0]    depth_q, depth_d;
   logic [AW-1:0]    wr_idx, top_idx;
   logic             do_push, do_pop;

   assign o_full  = (depth_q == DW'(DEPTH));
   assign o_empty = (depth_q == '0);
   assign do_push = i_push && !o_full;
   assign do_pop  = i_pop && !o_empty;

   // The next free slot is indexed by the depth itself; the top sits one below it.
   assign wr_idx  = depth_q[AW-1:0];
   assign top_idx = AW'(depth_q - 1'b1);

   assign o_data  = mem_q[top_idx];
   assign o_depth = depth_q;

   // Next depth: one op per cycle, so push and pop never coincide.
   always_comb begin
      depth_d = depth_q;
      if (do_push) begin
         depth_d = depth_q + 1'b1;
      end else if (do_pop) begin
         depth_d = depth_q - 1'b1;
      end
   end

   // Depth counter, cleared on reset.
   always_ff @(negedge i_clk) begin
      if (i_rst) begin
         depth_q <= '0;
      end else begin
         depth_q <= depth_d;
      end
   end

   // Entry storage; contents are don't-care after reset.
   always_ff @(negedge i_clk) begin
      if (do_push) begin
         mem_q[wr_idx] <= i_data;
      end
   end

endmodule

// File: rtl/pc_seq_unit.sv
// BIP-I program-counter sequencer: next/jump/branch/call/return/halt with an internal RAS.
// All state updates on the falling edge of i_clk.
// Optional: PC_TRAP_EN turns stack faults into a jump to TRAP_VEC with a one-cycle o_trap pulse.
module pc_seq_unit
   import pc_pkg::*;
#(
   parameter int               PCLEN     = 11,
   parameter int               RAS_DEPTH = 4,
   parameter logic [PCLEN-1:0] RESET_VEC = '0,
   parameter logic [PCLEN-1:0] TRAP_VEC  = '1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   pc_seq_unit_if.slave  bus
);

   localparam int DW = ras_depth_w(RAS_DEPTH);

   logic [PCLEN-1:0] pc_q, pc_d;
   pc_state_e        state_q, state_d;
   logic [PCLEN-1:0] ret_addr;
   logic [PCLEN-1:0] ras_top;
   logic [DW-1:0]    ras_depth;
   logic             ras_push, ras_pop, ras_full, ras_empty;
`ifdef PC_TRAP_EN
   logic             trap_q, trap_d;
`else
   logic [PCLEN-1:0] unused_trap_vec;
   assign unused_trap_vec = TRAP_VEC;
`endif

   // Sequential successor, wrapping from all-ones to zero.
   function automatic logic [PCLEN-1:0] pc_inc(input logic [PCLEN-1:0] pc);
      return pc + 1'b1;
   endfunction

   // Relative branch; the offset is two's complement and the sum wraps at PCLEN bits.
   function automatic logic [PCLEN-1:0] pc_branch(input logic [PCLEN-1:0]        pc,
                                                  input logic signed [PCLEN-1:0] off);
      logic signed [PCLEN-1:0] sum;
      sum = $signed(pc) + off;
      return $unsigned(sum);
   endfunction

   assign ret_addr = pc_inc(pc_q);

   pc_ras #(
      .WIDTH (PCLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (ras_push),
      .i_pop   (ras_pop),
      .i_data  (ret_addr),
      .o_data  (ras_top),
      .o_depth (ras_depth),
      .o_full  (ras_full),
      .o_empty (ras_empty)
   );

   // Next PC, next state and stack requests from the current op.
   always_comb begin
      pc_d     = pc_q;
      state_d  = state_q;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
`ifdef PC_TRAP_EN
      trap_d   = 1'b0;
`endif
      case (state_q)
         ST_RUN: begin
            if (bus.i_en) begin
               case (bus.i_op)
                  OP_NEXT:   pc_d = pc_inc(pc_q);
                  OP_JUMP:   pc_d = bus.i_target;
                  OP_BRANCH: pc_d = pc_branch(pc_q, bus.i_offset);
                  OP_CALL: begin
                     if (!ras_full) begin
                        ras_push = 1'b1;
                        pc_d     = bus.i_target;
                     end else begin
`ifdef PC_TRAP_EN
                        pc_d     = TRAP_VEC;
                        trap_d   = 1'b1;
`else
                        // Overflow drops the return address but still takes the call.
                        pc_d     = bus.i_target;
`endif
                     end
                  end
                  OP_RET: begin
                     if (!ras_empty) begin
                        ras_pop = 1'b1;
                        pc_d    = ras_top;
                     end else begin
`ifdef PC_TRAP_EN
                        pc_d    = TRAP_VEC;
                        trap_d  = 1'b1;
`else
                        // Underflow degrades to a plain sequential step.
                        pc_d    = pc_inc(pc_q);
`endif
                     end
                  end
                  OP_HALT:   state_d = ST_HALT;
                  default:   pc_d = pc_q;
               endcase
            end
         end
         ST_HALT: begin
            if (bus.i_resume) begin
               state_d = ST_RUN;
            end
         end
      endcase
   end

   // PC and control state registers; reset has priority over everything.
   always_ff @(negedge i_clk) begin
      if (i_rst) begin
         pc_q    <= RESET_VEC;
         state_q <= ST_RUN;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
      end
   end

`ifdef PC_TRAP_EN
   // Stack-fault pulse, high for the single cycle after the faulting op.
   always_ff @(negedge i_clk) begin
      if (i_rst) begin
         trap_q <= 1'b0;
      end else begin
         trap_q <= trap_d;
      end
   end

   assign bus.o_trap = trap_q;
`endif

   assign bus.o_PCval     = pc_q;
   assign bus.o_halted    = (state_q == ST_HALT);
   assign bus.o_ras_depth = ras_depth;
   assign bus.o_ras_full  = ras_full;
   assign bus.o_ras_empty = ras_empty;

endmodule

// File: tb/tb_pc_seq_unit.sv
// Bench for pc_seq_unit: directed scenarios followed by randomized ops,
// all checked against a queue-based reference model of the sequencer.
// Build with or without PC_TRAP_EN; the model follows the same macro.
module tb_pc_seq_unit;

   localparam int PCLEN     = 11;
   localparam int RAS_DEPTH = 4;
   localparam int M         = 1 << PCLEN;
   localparam int RST_PC    = 0;
`ifdef PC_TRAP_EN
   localparam int TRAP_PC   = M - 1;
`endif

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   pc_seq_unit_if #(.PCLEN(PCLEN), .RAS_DEPTH(RAS_DEPTH)) bus ();

   pc_seq_unit #(
      .PCLEN     (PCLEN),
      .RAS_DEPTH (RAS_DEPTH)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_mis = 0;

   // Reference model state.
   int m_pc   = 0;
   int m_stk[$];
   bit m_halt = 1'b0;
   bit m_trap = 1'b0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit en, input int op, input int tgt,
                        input int off, input bit res);
      m_trap = 1'b0;
      if (r) begin
         m_pc   = RST_PC;
         m_stk.delete();
         m_halt = 1'b0;
         return;
      end
      if (m_halt) begin
         if (res) m_halt = 1'b0;
         return;
      end
      if (!en) return;
      case (op)
         0: m_pc = (m_pc + 1) % M;
         1: m_pc = tgt;
         2: m_pc = (m_pc + off) % M;
         3: begin
            if (m_stk.size() == RAS_DEPTH) begin
`ifdef PC_TRAP_EN
               m_pc   = TRAP_PC;
               m_trap = 1'b1;
`else
               m_pc   = tgt;
`endif
            end else begin
               m_stk.push_back((m_pc + 1) % M);
               m_pc = tgt;
            end
         end
         4: begin
            if (m_stk.size() == 0) begin
`ifdef PC_TRAP_EN
               m_pc   = TRAP_PC;
               m_trap = 1'b1;
`else
               m_pc   = (m_pc + 1) % M;
`endif
            end else begin
               m_pc = m_stk.pop_back();
            end
         end
         5: m_halt = 1'b1;
         default: ;
      endcase
   endtask

   task automatic compare_all();
      chk("pc",     int'(bus.o_PCval),     m_pc);
      chk("halted", int'(bus.o_halted),    int'(m_halt));
      chk("depth",  int'(bus.o_ras_depth), m_stk.size());
      chk("full",   int'(bus.o_ras_full),  int'(m_stk.size() == RAS_DEPTH));
      chk("empty",  int'(bus.o_ras_empty), int'(m_stk.size() == 0));
`ifdef PC_TRAP_EN
      chk("trap",   int'(bus.o_trap),      int'(m_trap));
`endif
   endtask

   // Drive one cycle of inputs away from the active (falling) edge, then check after it.
   task automatic step(input bit r, input bit en, input int op, input int tgt,
                       input int off, input bit res);
      @(posedge clk);
      rst          = r;
      bus.i_en     = en;
      bus.i_op     = 3'(op);
      bus.i_target = PCLEN'(tgt);
      bus.i_offset = PCLEN'(off);
      bus.i_resume = res;
      model(r, en, op, tgt % M, off % M, res);
      @(negedge clk);
      #1;
      compare_all();
   endtask

   task automatic do_rst();       step(1'b1, 1'b0, 0, 0, 0, 1'b0); endtask
   task automatic do_op(input int op, input int tgt, input int off);
      step(1'b0, 1'b1, op, tgt, off, 1'b0);
   endtask

   initial begin
      bus.i_en     = 1'b0;
      bus.i_op     = '0;
      bus.i_target = '0;
      bus.i_offset = '0;
      bus.i_resume = 1'b0;

      // Reset, sequential count, hold with enable low.
      do_rst();
      chk("rst_pc", int'(bus.o_PCval), 0);
      chk("rst_empty", int'(bus.o_ras_empty), 1);
      for (int i = 0; i < 3; i++) do_op(0, 0, 0);
      chk("seq3", int'(bus.o_PCval), 3);
      for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1, 12'h155, 0, 1'b0);
      chk("hold", int'(bus.o_PCval), 3);

      // Wrap and negative branch.
      do_op(1, 12'h7FF, 0);
      do_op(0, 0, 0);
      chk("wrap", int'(bus.o_PCval), 0);
      do_op(1, 12'h005, 0);
      do_op(2, 0, 12'h7FE);
      chk("branch_neg", int'(bus.o_PCval), 3);

      // Nested call/return.
      do_op(1, 12'h010, 0);
      do_op(3, 12'h100, 0);
      chk("call1", int'(bus.o_PCval), 12'h100);
      do_op(3, 12'h200, 0);
      chk("call2_depth", int'(bus.o_ras_depth), 2);
      do_op(4, 0, 0);
      chk("ret1", int'(bus.o_PCval), 12'h101);
      do_op(4, 0, 0);
      chk("ret2", int'(bus.o_PCval), 12'h011);
      chk("ret2_depth", int'(bus.o_ras_depth), 0);

      // Overflow on the fifth call, then reset with a full stack.
      for (int i = 0; i < 4; i++) do_op(3, 12'h300 + i, 0);
      chk("full4", int'(bus.o_ras_full), 1);
      chk("depth4", int'(bus.o_ras_depth), 4);
      do_op(3, 12'h304, 0);
`ifdef PC_TRAP_EN
      chk("call_ovf_pc", int'(bus.o_PCval), 12'h7FF);
      chk("call_ovf_trap", int'(bus.o_trap), 1);
`else
      chk("call_ovf_pc", int'(bus.o_PCval), 12'h304);
`endif
      chk("call_ovf_depth", int'(bus.o_ras_depth), 4);
      do_op(0, 0, 0);
      do_rst();
      chk("rst_full_depth", int'(bus.o_ras_depth), 0);

      // Underflow.
      do_op(1, 12'h020, 0);
      do_op(4, 0, 0);
`ifdef PC_TRAP_EN
      chk("ret_unf_pc", int'(bus.o_PCval), 12'h7FF);
      chk("ret_unf_trap", int'(bus.o_trap), 1);
      do_op(0, 0, 0);
      chk("trap_one_cycle", int'(bus.o_trap), 0);
`else
      chk("ret_unf_pc", int'(bus.o_PCval), 12'h021);
`endif

      // Halt, ignore ops, resume, reset while halted.
      do_op(1, 12'h040, 0);
      do_op(5, 0, 0);
      chk("halted", int'(bus.o_halted), 1);
      for (int i = 0; i < 3; i++) do_op(0, 0, 0);
      chk("halt_hold", int'(bus.o_PCval), 12'h040);
      step(1'b0, 1'b1, 0, 0, 0, 1'b1);
      chk("resume", int'(bus.o_halted), 0);
      chk("resume_pc", int'(bus.o_PCval), 12'h040);
      do_op(0, 0, 0);
      chk("after_resume", int'(bus.o_PCval), 12'h041);
      do_op(5, 0, 0);
      do_rst();
      chk("rst_halt_pc", int'(bus.o_PCval), 0);
      chk("rst_halt_flag", int'(bus.o_halted), 0);

      // Randomized ops against the model.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) == 0,
              $urandom_range(0, 7) != 0,
              int'($urandom_range(0, 7)),
              int'($urandom_range(0, M - 1)),
              int'($urandom_range(0, M - 1)),
              $urandom_range(0, 3) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
